// File: rtl/seq_ptn_loader_pkg.sv
// Shared definitions for the seq pattern loader and the seq player.
//   - default geometry of one pattern table
//   - entry / table width helpers
//   - the two-state loader FSM encoding (FILL=0, COMMIT=1)
package seq_ptn_loader_pkg;

  localparam int BW_SEQ_DEF     = 4;
  localparam int SEQ_CNT_DEF    = 7;
  localparam int BW_SEQ_CNT_DEF = 3;
  localparam int BW_TIMEOUT_DEF = 2;

  // One entry is {seq, timeout}, timeout in the low bits.
  function automatic int entry_w(input int bw_seq, input int bw_timeout);
    return bw_seq + bw_timeout;
  endfunction

  // Whole table: SEQ_CNT+1 entries, slot k at [entry_w*k +: entry_w].
  function automatic int table_w(input int bw_seq, input int bw_timeout, input int seq_cnt);
    return entry_w(bw_seq, bw_timeout) * (seq_cnt + 1);
  endfunction

  localparam int ENTRY_W_DEF = BW_SEQ_DEF + BW_TIMEOUT_DEF;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_COMMIT = 1'b1
  } ld_state_e;

endpackage

// File: rtl/seq_ptn_loader_if.sv
// Entry write port of the pattern loader (valid/ready).
//   WR_VALID  master->slave  entry valid
//   WR_READY  slave->master  loader can accept an entry
//   WR_DATA   master->slave  {seq, timeout}
//   WR_LAST   master->slave  final entry of a table, qualified by transfer
interface seq_ptn_loader_if
  import seq_ptn_loader_pkg::*;
#(
  parameter int EW = ENTRY_W_DEF
);
  logic          WR_VALID;
  logic          WR_READY;
  logic [EW-1:0] WR_DATA;
  logic          WR_LAST;

  modport master (output WR_VALID, output WR_DATA, output WR_LAST, input  WR_READY);
  modport slave  (input  WR_VALID, input  WR_DATA, input  WR_LAST, output WR_READY);
endinterface

// File: rtl/seq_ptn_loader_cnt_down.sv
// cnt_down: loadable down counter used as the loader's slot index.
//   clk, rst_n  clock, async active-low reset (count returns to RST_VAL)
//   load, val   load val (has priority over dec)
//   dec         decrement by one
//   cnt         current count
module cnt_down #(
  parameter int            W       = 3,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = val;
    else if (dec) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/seq_ptn_loader.sv
// seq_ptn_loader: assembles pattern entries into a shadow table and commits
// whole tables to PTN, pulsing CLR so seq restarts on the new pattern.
//   CLK, RSTX   clock, async active-low reset
//   wr          entry write port (slave side)
//   ABORT       discard the partially loaded table (FILL only)
//   PTN         committed table, slot SEQ_CNT is played first
//   CLR         one-cycle restart pulse, PTN already new in that cycle
//   ERR         one-cycle pulse: WR_LAST position mismatch, table dropped
// The first entry of a table lands in slot SEQ_CNT, the last in slot 0.
module seq_ptn_loader
  import seq_ptn_loader_pkg::*;
#(
  parameter int BW_SEQ     = BW_SEQ_DEF,
  parameter int SEQ_CNT    = SEQ_CNT_DEF,
  parameter int BW_SEQ_CNT = BW_SEQ_CNT_DEF,
  parameter int BW_TIMEOUT = BW_TIMEOUT_DEF,
  parameter logic [(BW_SEQ+BW_TIMEOUT)*(SEQ_CNT+1)-1:0] PTN_INIT = '0
) (
  input  logic                                          CLK,
  input  logic                                          RSTX,
  seq_ptn_loader_if.slave                               wr,
  input  logic                                          ABORT,
  output logic [table_w(BW_SEQ, BW_TIMEOUT, SEQ_CNT)-1:0] PTN,
  output logic                                          CLR,
  output logic                                          ERR
);
  localparam int EW = entry_w(BW_SEQ, BW_TIMEOUT);
  localparam int TW = table_w(BW_SEQ, BW_TIMEOUT, SEQ_CNT);
  localparam logic [BW_SEQ_CNT-1:0] IDX_TOP = BW_SEQ_CNT'(SEQ_CNT);

  ld_state_e                  state_q, state_d;
  logic [SEQ_CNT:0][EW-1:0]   shadow_q, shadow_d;
  logic [TW-1:0]              ptn_q, ptn_d;
  logic                       clr_q, clr_d;
  logic                       err_q, err_d;

  logic [BW_SEQ_CNT-1:0]      idx;
  logic                       idx_load, idx_dec;
  logic                       xfer;

  // Ready depends only on state, so the handshake has no input->output path.
  assign wr.WR_READY = (state_q == ST_FILL);
  assign xfer        = wr.WR_VALID & wr.WR_READY;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ptn_d    = ptn_q;
    clr_d    = 1'b0;
    err_d    = 1'b0;
    idx_load = 1'b0;
    idx_dec  = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (ABORT) begin
          // Rewinding idx is enough to drop the table: stale slots are
          // always overwritten before the next commit can happen.
          idx_load = 1'b1;
        end else if (xfer) begin
          shadow_d[idx] = wr.WR_DATA;
          if (wr.WR_LAST && idx == '0) begin
            state_d = ST_COMMIT;
          end else if (wr.WR_LAST || idx == '0) begin
            err_d    = 1'b1;
            idx_load = 1'b1;
          end else begin
            idx_dec = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        // ABORT is deliberately not looked at here: the commit always completes.
        ptn_d    = shadow_q;
        clr_d    = 1'b1;
        idx_load = 1'b1;
        state_d  = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q  <= ST_FILL;
      shadow_q <= '0;
      ptn_q    <= PTN_INIT;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ptn_q    <= ptn_d;
      clr_q    <= clr_d;
      err_q    <= err_d;
    end
  end

  cnt_down #(
    .W       (BW_SEQ_CNT),
    .RST_VAL (IDX_TOP)
  ) u_idx (
    .clk   (CLK),
    .rst_n (RSTX),
    .load  (idx_load),
    .val   (IDX_TOP),
    .dec   (idx_dec),
    .cnt   (idx)
  );

  assign PTN = ptn_q;
  assign CLR = clr_q;
  assign ERR = err_q;
endmodule
